minimig_grid: RTL and testbench

MINIMIG_GRID -- requirements
Module: minimig_grid

---
 rtl/minimig_grid.sv | 252 +++++++++++++++++++++++++
 tb/tb_minimig_grid.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/minimig_grid.sv
// rtl/minimig_grid.sv - DVI grid pattern generator with PS/2 scan-code status display
//
// Draws a white grid on a navy background, TMDS encodes each pixel and shifts
// every lane out one bit per xclk (10 xclk per pixel).
// Optional feature macro: MINIMIG_GRID_PS2_EN
//   defined   : PS/2 keyboard receiver built, led shows the last valid scan code
//   undefined : kclk/kd ignored, led counts frames
//
// Ports:
//   xclk                              sole clock
//   cpu_reset                         asynchronous active-high reset
//   kclk, kd                          PS/2 keyboard clock and data (asynchronous)
//   led[7:0]                          status display
//   TMDS_OUT_clk_p / _n               serial clock lane, 1111100000 per word
//   TMDS_OUT_data_p[2:0] / _n[2:0]    serial data lanes: bit0 blue, bit1 green, bit2 red
module minimig_grid #(
   parameter logic SIM = 1'b0
) (
   input  logic       xclk,
   input  logic       cpu_reset,
   input  logic       kclk,
   input  logic       kd,
   output logic [7:0] led,
   output logic       TMDS_OUT_clk_p,
   output logic       TMDS_OUT_clk_n,
   output logic [2:0] TMDS_OUT_data_p,
   output logic [2:0] TMDS_OUT_data_n
);

   // Sync start (SS) and sync end (SE, exclusive) positions
   localparam logic [9:0]  H_ACT   = SIM ? 10'd16 : 10'd640;
   localparam logic [9:0]  H_SS    = SIM ? 10'd18 : 10'd656;
   localparam logic [9:0]  H_SE    = SIM ? 10'd22 : 10'd752;
   localparam logic [9:0]  H_LAST  = SIM ? 10'd23 : 10'd799;
   localparam logic [9:0]  V_ACT   = SIM ? 10'd8  : 10'd480;
   localparam logic [9:0]  V_SS    = SIM ? 10'd9  : 10'd490;
   localparam logic [9:0]  V_SE    = SIM ? 10'd11 : 10'd492;
   localparam logic [9:0]  V_LAST  = SIM ? 10'd11 : 10'd524;
   localparam int          G       = SIM ? 2 : 4;
   localparam logic [16:0] TO_LAST = SIM ? 17'd255 : 17'd65535;

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   // DVI 8b/10b encoder; returns {new_disparity[5:0], word[9:0]}
   function automatic logic [15:0] tmds_enc(
      input logic [7:0]        d,
      input logic              de_in,
      input logic [1:0]        c,
      input logic signed [5:0] cnt
   );
      logic [8:0] qm;
      logic [9:0] q;
      int         n1d, n1q, n0q, cn;
      n1d = 0;
      n1q = 0;
      for (int i = 0; i < 8; i++) n1d = n1d + int'(d[i]);
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && !d[0])) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      for (int i = 0; i < 8; i++) n1q = n1q + int'(qm[i]);
      n0q = 8 - n1q;
      cn  = int'(cnt);
      q   = '0;
      if (!de_in) begin
         cn = 0;
         case (c)
            2'b00:   q = TOK_00;
            2'b01:   q = TOK_01;
            2'b10:   q = TOK_10;
            default: q = TOK_11;
         endcase
      end else if (cn == 0 || n1q == n0q) begin
         q  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cn = qm[8] ? cn + n1q - n0q : cn + n0q - n1q;
      end else if ((cn > 0 && n1q > n0q) || (cn < 0 && n0q > n1q)) begin
         q  = {1'b1, qm[8], ~qm[7:0]};
         cn = cn + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
         q  = {1'b0, qm[8], qm[7:0]};
         cn = cn - (qm[8] ? 0 : 2) + n1q - n0q;
      end
      return {6'(cn), q};
   endfunction

   // Pixel enable: one pulse per 10 xclk, on count 9
   logic [3:0] pix_cnt;
   logic       pix_en;
   assign pix_en = (pix_cnt == 4'd9);

   always_ff @(posedge xclk or posedge cpu_reset) begin
      if (cpu_reset) pix_cnt <= '0;
      else           pix_cnt <= pix_en ? 4'd0 : pix_cnt + 4'd1;
   end

   // Raster counters
   logic [9:0] hcount, vcount;

   always_ff @(posedge xclk or posedge cpu_reset) begin
      if (cpu_reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_en) begin
         if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
         end else begin
            hcount <= hcount + 10'd1;
         end
      end
   end

   // Pattern and active-low syncs
   logic       de, hsync, vsync, grid;
   logic [7:0] red, green, blue;

   always_comb begin
      de    = (hcount < H_ACT) && (vcount < V_ACT);
      hsync = !((hcount >= H_SS) && (hcount < H_SE));
      vsync = !((vcount >= V_SS) && (vcount < V_SE));
      grid  = (hcount[G-1:0] == '0) || (vcount[G-1:0] == '0);
      red   = grid ? 8'hFF : 8'h00;
      green = grid ? 8'hFF : 8'h00;
      blue  = grid ? 8'hFF : 8'h80;
   end

   // Encode stage, registered on pixel enable
   logic [9:0]        enc_b, enc_g, enc_r;
   logic signed [5:0] disp_b, disp_g, disp_r;
   logic [15:0]       nxt_b, nxt_g, nxt_r;

   assign nxt_b = tmds_enc(blue,  de, {vsync, hsync}, disp_b);
   assign nxt_g = tmds_enc(green, de, 2'b00,          disp_g);
   assign nxt_r = tmds_enc(red,   de, 2'b00,          disp_r);

   always_ff @(posedge xclk or posedge cpu_reset) begin
      if (cpu_reset) begin
         enc_b  <= '0;
         enc_g  <= '0;
         enc_r  <= '0;
         disp_b <= '0;
         disp_g <= '0;
         disp_r <= '0;
      end else if (pix_en) begin
         enc_b  <= nxt_b[9:0];
         enc_g  <= nxt_g[9:0];
         enc_r  <= nxt_r[9:0];
         disp_b <= nxt_b[15:10];
         disp_g <= nxt_g[15:10];
         disp_r <= nxt_r[15:10];
      end
   end

   // Serialisers; the clock lane is a shifter too so it idles low in reset
   logic [9:0] sh_b, sh_g, sh_r, sh_c;

   always_ff @(posedge xclk or posedge cpu_reset) begin
      if (cpu_reset) begin
         sh_b <= '0;
         sh_g <= '0;
         sh_r <= '0;
         sh_c <= '0;
      end else if (pix_en) begin
         sh_b <= enc_b;
         sh_g <= enc_g;
         sh_r <= enc_r;
         sh_c <= 10'b0000011111;
      end else begin
         sh_b <= {1'b0, sh_b[9:1]};
         sh_g <= {1'b0, sh_g[9:1]};
         sh_r <= {1'b0, sh_r[9:1]};
         sh_c <= {1'b0, sh_c[9:1]};
      end
   end

   assign TMDS_OUT_clk_p  = sh_c[0];
   assign TMDS_OUT_clk_n  = ~sh_c[0];
   assign TMDS_OUT_data_p = {sh_r[0], sh_g[0], sh_b[0]};
   assign TMDS_OUT_data_n = ~{sh_r[0], sh_g[0], sh_b[0]};

`ifdef MINIMIG_GRID_PS2_EN
   // kclk_s[1]/kd_s[1] are the synchronised levels, kclk_s[2] the previous one
   logic [2:0]  kclk_s;
   logic [1:0]  kd_s;
   logic        kfall;
   logic [3:0]  bit_cnt;
   logic [9:0]  sr;
   logic [10:0] frame;
   logic        frame_rdy;
   logic [16:0] idle;

   assign kfall = kclk_s[2] & ~kclk_s[1];

   always_ff @(posedge xclk or posedge cpu_reset) begin
      if (cpu_reset) begin
         kclk_s    <= '0;
         kd_s      <= '0;
         bit_cnt   <= '0;
         sr        <= '0;
         frame     <= '0;
         frame_rdy <= 1'b0;
         idle      <= '0;
         led       <= '0;
      end else begin
         kclk_s    <= {kclk_s[1:0], kclk};
         kd_s      <= {kd_s[0], kd};
         frame_rdy <= 1'b0;
         // start 0, stop 1, odd parity over data + parity bit
         if (frame_rdy && !frame[0] && frame[10] && (^frame[9:1]))
            led <= frame[8:1];
         if (kfall) begin
            idle <= '0;
            if (bit_cnt == 4'd10) begin
               frame     <= {kd_s[1], sr};
               frame_rdy <= 1'b1;
               bit_cnt   <= '0;
            end else begin
               sr      <= {kd_s[1], sr[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            // a stalled partial frame is dropped so the next start bit realigns
            if (idle == TO_LAST) begin
               bit_cnt <= '0;
               idle    <= '0;
            end else begin
               idle <= idle + 17'd1;
            end
         end
      end
   end
`else
   logic frame_wrap;
   logic unused_ps2;

   assign frame_wrap = pix_en && (hcount == H_LAST) && (vcount == V_LAST);
   assign unused_ps2 = kclk ^ kd;

   always_ff @(posedge xclk or posedge cpu_reset) begin
      if (cpu_reset)       led <= '0;
      else if (frame_wrap) led <= led + 8'd1;
   end
`endif

endmodule

// File: tb/tb_minimig_grid.sv
// tb/tb_minimig_grid.sv - directed self-checking bench for minimig_grid (SIM timing)
`timescale 1ns/1ps
module tb_minimig_grid;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam int         NW  = 290;

   logic       xclk = 1'b0;
   logic       cpu_reset = 1'b1;
   logic       kclk = 1'b1;
   logic       kd = 1'b1;
   logic [7:0] led;
   logic       clk_p, clk_n;
   logic [2:0] dp, dn;

   int n_tests = 0;
   int n_fail  = 0;
   int ecount  = 0;
   int inv_bad = 0;
   int wi, bi;

   logic [9:0] w_b [NW];
   logic [9:0] w_g [NW];
   logic [9:0] w_r [NW];
   logic [9:0] w_c [NW];

   always #5 xclk = ~xclk;

   minimig_grid #(.SIM(1'b1)) dut (
      .xclk            (xclk),
      .cpu_reset       (cpu_reset),
      .kclk            (kclk),
      .kd              (kd),
      .led             (led),
      .TMDS_OUT_clk_p  (clk_p),
      .TMDS_OUT_clk_n  (clk_n),
      .TMDS_OUT_data_p (dp),
      .TMDS_OUT_data_n (dn)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] dec(input logic [9:0] w);
      logic [7:0] q, d;
      q    = w[9] ? ~w[7:0] : w[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   task automatic wait_edges(input int n);
      while (ecount < n) @(negedge xclk);
   endtask

`ifdef MINIMIG_GRID_PS2_EN
   task automatic send_ps2(input logic [7:0] data, input logic bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kd = f[i];
         repeat (20) @(negedge xclk);
         kclk = 1'b0;
         repeat (20) @(negedge xclk);
         kclk = 1'b1;
      end
      repeat (20) @(negedge xclk);
      kd = 1'b1;
   endtask
`endif

   always @(posedge xclk) begin
      if (cpu_reset) ecount = 0;
      else           ecount = ecount + 1;
   end

   // word w, slot b is on the lanes between edges 10+10w+b and the next edge
   always @(negedge xclk) begin
      if (!cpu_reset) begin
         if ({clk_n, dn} !== ~{clk_p, dp}) inv_bad = inv_bad + 1;
         if (ecount >= 10) begin
            wi = (ecount - 10) / 10;
            bi = (ecount - 10) % 10;
            if (wi < NW) begin
               w_b[wi][bi] = dp[0];
               w_g[wi][bi] = dp[1];
               w_r[wi][bi] = dp[2];
               w_c[wi][bi] = clk_p;
            end
         end
      end
   end

   initial begin
      int         bad, cbad, hs_cnt, h, v;
      logic       hs, vs;
      logic [9:0] eb;

      repeat (20) @(negedge xclk);
      check("rst_led", led, 8'h00);
      check("rst_lanes", {clk_p, dp, clk_n, dn}, 8'b0000_1111);
      cpu_reset = 1'b0;

      wait_edges(9);
      check("pre_first_pix_en", {clk_p, dp}, 4'h0);

      wait_edges(10 + 10 * NW);
      check("clk_word0", w_c[0], 10'b0000011111);
      cbad = 0;
      for (int i = 0; i < NW; i++) if (w_c[i] !== 10'b0000011111) cbad++;
      check("clk_words_bad", cbad, 0);

      // pixel p of the first frame is word p+1
      check("px00_words", {w_b[1], w_g[1], w_r[1]}, {10'h200, 10'h200, 10'h200});
      check("px00_dec", {dec(w_b[1]), dec(w_g[1]), dec(w_r[1])}, 24'hFFFFFF);
      check("px11_dec", {dec(w_b[26]), dec(w_g[26]), dec(w_r[26])}, 24'h800000);
      check("px10_dec", {dec(w_b[2]), dec(w_g[2]), dec(w_r[2])}, 24'hFFFFFF);
      check("front_porch", {w_b[17], w_g[17], w_r[17]}, {T11, T00, T00});
      check("hsync_lanes", {w_b[19], w_g[19], w_r[19]}, {T10, T00, T00});
      check("vsync_line_blue", w_b[9 * 24 + 1], T01);
      check("vsync_hsync_blue", w_b[9 * 24 + 19], T00);

      hs_cnt = 0;
      for (int i = 1; i <= 24; i++) if (w_b[i] === T10) hs_cnt++;
      check("hsync_row0_len", hs_cnt, 4);

      bad = 0;
      for (int p = 0; p < 288; p++) begin
         h = p % 24;
         v = p / 24;
         if (h < 16 && v < 8) begin
            if ((h % 4 == 0) || (v % 4 == 0)) begin
               if ({dec(w_b[p+1]), dec(w_g[p+1]), dec(w_r[p+1])} !== 24'hFFFFFF) bad++;
            end else begin
               if ({dec(w_b[p+1]), dec(w_g[p+1]), dec(w_r[p+1])} !== 24'h800000) bad++;
            end
         end else begin
            hs = !(h >= 18 && h < 22);
            vs = !(v >= 9 && v < 11);
            case ({vs, hs})
               2'b00:   eb = T00;
               2'b01:   eb = T01;
               2'b10:   eb = T10;
               default: eb = T11;
            endcase
            if ({w_b[p+1], w_g[p+1], w_r[p+1]} !== {eb, T00, T00}) bad++;
         end
      end
      check("frame_sweep_bad", bad, 0);
      check("frame2_px00", {w_b[289], w_g[289], w_r[289]}, {10'h200, 10'h200, 10'h200});

`ifdef MINIMIG_GRID_PS2_EN
      send_ps2(8'h1C, 1'b0, 11);
      repeat (30) @(negedge xclk);
      check("ps2_1c", led, 8'h1C);
      send_ps2(8'h32, 1'b1, 11);
      repeat (30) @(negedge xclk);
      check("ps2_bad_parity", led, 8'h1C);
      send_ps2(8'h5A, 1'b0, 5);
      repeat (400) @(negedge xclk);
      send_ps2(8'h5A, 1'b0, 11);
      repeat (30) @(negedge xclk);
      check("ps2_timeout", led, 8'h5A);
`else
      wait_edges(8639);
      check("led_before_3rd_wrap", led, 8'd2);
      wait_edges(8640);
      check("led_3_frames", led, 8'd3);
`endif

      wait_edges(8640 + 1234);
      cpu_reset = 1'b1;
      #1;
      check("mid_rst_led", led, 8'h00);
      check("mid_rst_lanes", {clk_p, dp, clk_n, dn}, 8'b0000_1111);
      for (int i = 0; i < NW; i++) begin
         w_b[i] = '0;
         w_g[i] = '0;
         w_r[i] = '0;
         w_c[i] = '0;
      end
      repeat (5) @(negedge xclk);
      cpu_reset = 1'b0;
      wait_edges(30);
      check("restart_px00", {w_b[1], w_g[1], w_r[1]}, {10'h200, 10'h200, 10'h200});
      check("restart_clk_word", w_c[0], 10'b0000011111);
      check("n_is_inverse", inv_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
